// File: rtl/cvw_pkg.sv
// ============================================================================
// cvw_pkg : core configuration type, CLINT register offsets, byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package cvw_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_RV64 = '{XLEN: 64};
    localparam cvw_t CVW_RV32 = '{XLEN: 32};

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    // Replace each byte of old_val whose enable bit is set with the same byte of wdata.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  be);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clint_prescaler.sv
// ============================================================================
// clint_prescaler : timebase divider producing a one-cycle mtime tick
// Rev 1.0
// ============================================================================
`default_nettype none

module clint_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stop_i,
    input  logic clear_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       wrap;

    assign wrap   = (cnt_q == 8'(DIV - 1));
    assign tick_o = wrap & ~stop_i;

    // A clear (mtime write) restarts the phase even while time is stopped.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!stop_i) begin
            cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clint_timer.sv
// ============================================================================
// clint_timer : APB core-local interruptor (mtime, mtimecmp, msip)
// Rev 1.0
// ============================================================================
`default_nettype none

module clint_timer
    import cvw_pkg::*;
#(
    parameter cvw_t P            = CVW_RV64,
    parameter int   TIMEBASE_DIV = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic [15:0]           PADDR,
    input  logic [P.XLEN-1:0]     PWDATA,
    input  logic [P.XLEN/8-1:0]   PSTRB,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    input  logic                  DebugStopTime,
    input  logic                  DebugMode,
    output logic [P.XLEN-1:0]     PRDATA,
    output logic                  PREADY,
    output logic [63:0]           MTIME_CLINT,
    output logic                  MTimerInt,
    output logic                  MSwInt
);

    localparam int XLEN = P.XLEN;

    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            msip_q, msip_d;
    logic            mtip_q, mtip_d;
    logic [XLEN-1:0] prdata_q, prdata_d;
    logic [XLEN-1:0] rdata;
    logic [63:0]     wdata64;
    logic [7:0]      mtime_be, mtimecmp_be;
    logic            wr_en, rd_en, stop, tick, msip_we;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & ~PENABLE;
    assign stop    = DebugMode & DebugStopTime;
    assign msip_we = wr_en & (PADDR == CLINT_MSIP_OFS) & PSTRB[0];

    // Bus lanes are mapped onto the 64-bit registers as byte enables so one merge serves both widths.
    if (XLEN == 64) begin : g_xlen64
        logic hit_cmp, hit_time;

        assign hit_cmp     = (PADDR == CLINT_MTIMECMP_OFS);
        assign hit_time    = (PADDR == CLINT_MTIME_OFS);
        assign wdata64     = PWDATA;
        assign mtimecmp_be = (wr_en && hit_cmp)  ? PSTRB : 8'h00;
        assign mtime_be    = (wr_en && hit_time) ? PSTRB : 8'h00;

        always_comb begin
            rdata = '0;
            if (PADDR == CLINT_MSIP_OFS) begin
                rdata[0] = msip_q;
            end else if (hit_cmp) begin
                rdata = mtimecmp_q;
            end else if (hit_time) begin
                rdata = mtime_q;
            end
        end
    end else begin : g_xlen32
        logic       hit_cmp, hit_time;
        logic [7:0] be_word;

        assign hit_cmp  = ({PADDR[15:3], 3'b000} == CLINT_MTIMECMP_OFS) && (PADDR[1:0] == 2'b00);
        assign hit_time = ({PADDR[15:3], 3'b000} == CLINT_MTIME_OFS) && (PADDR[1:0] == 2'b00);
        assign wdata64  = {PWDATA, PWDATA};
        assign be_word  = PADDR[2] ? {PSTRB, 4'h0} : {4'h0, PSTRB};
        assign mtimecmp_be = (wr_en && hit_cmp)  ? be_word : 8'h00;
        assign mtime_be    = (wr_en && hit_time) ? be_word : 8'h00;

        always_comb begin
            rdata = '0;
            if (PADDR == CLINT_MSIP_OFS) begin
                rdata[0] = msip_q;
            end else if (hit_cmp) begin
                rdata = PADDR[2] ? mtimecmp_q[63:32] : mtimecmp_q[31:0];
            end else if (hit_time) begin
                rdata = PADDR[2] ? mtime_q[63:32] : mtime_q[31:0];
            end
        end
    end

    clint_prescaler #(
        .DIV     (TIMEBASE_DIV)
    ) u_prescaler (
        .clk_i   (PCLK),
        .rst_n_i (PRESETn),
        .stop_i  (stop),
        .clear_i (|mtime_be),
        .tick_o  (tick)
    );

    // A software write to mtime wins over a coincident tick; unwritten bytes are not incremented.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (|mtime_be) begin
            mtime_d = byte_merge(mtime_q, wdata64, mtime_be);
        end
        mtimecmp_d = byte_merge(mtimecmp_q, wdata64, mtimecmp_be);
        msip_d     = msip_we ? PWDATA[0] : msip_q;
        mtip_d     = (mtime_d >= mtimecmp_d);
        prdata_d   = rd_en ? rdata : prdata_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            prdata_q   <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            prdata_q   <= prdata_d;
        end
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = 1'b1;
    assign MTIME_CLINT = mtime_q;
    assign MTimerInt   = mtip_q;
    assign MSwInt      = msip_q;

endmodule

`default_nettype wire

// File: tb/tb_clint_timer.sv
// ============================================================================
// tb_clint_timer : RV64/div-1 and RV32/div-4 instances against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clint_timer;
    import cvw_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        dbg_mode, dbg_stop;

    logic [63:0] d64_prdata, d64_mtime, d32_mtime;
    logic [31:0] d32_prdata;
    logic        d64_pready, d64_mtip, d64_msip;
    logic        d32_pready, d32_mtip, d32_msip;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;

    clint_timer #(.P(CVW_RV64), .TIMEBASE_DIV(1)) u_d64 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PADDR(paddr),
        .PWDATA(pwdata), .PSTRB(pstrb), .PWRITE(pwrite), .PENABLE(penable),
        .DebugStopTime(dbg_stop), .DebugMode(dbg_mode),
        .PRDATA(d64_prdata), .PREADY(d64_pready), .MTIME_CLINT(d64_mtime),
        .MTimerInt(d64_mtip), .MSwInt(d64_msip)
    );

    clint_timer #(.P(CVW_RV32), .TIMEBASE_DIV(4)) u_d32 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PADDR(paddr),
        .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PWRITE(pwrite), .PENABLE(penable),
        .DebugStopTime(dbg_stop), .DebugMode(dbg_mode),
        .PRDATA(d32_prdata), .PREADY(d32_pready), .MTIME_CLINT(d32_mtime),
        .MTimerInt(d32_mtip), .MSwInt(d32_msip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model: index 0 = RV64/div 1, index 1 = RV32/div 4
    logic [63:0] m_time   [2];
    logic [63:0] m_cmp    [2];
    logic        m_msip   [2];
    int          m_pre    [2];
    logic        m_mtip   [2];
    logic [63:0] m_prdata [2];

    function automatic int divk(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int nbk(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic logic [63:0] model_read(input int k, input logic [15:0] a);
        logic [63:0] r;
        int ai;
        ai = int'(a);
        r  = '0;
        if (ai == 0) begin
            r = {63'd0, m_msip[k]};
        end else if ((ai % nbk(k)) == 0) begin
            if (ai >= 'h4000 && ai < 'h4008) r = m_cmp[k] >> ((ai - 'h4000) * 8);
            else if (ai >= 'hBFF8 && ai < 'hC000) r = m_time[k] >> ((ai - 'hBFF8) * 8);
        end
        if (nbk(k) == 4) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_time[k] = '0; m_cmp[k] = '1; m_msip[k] = 1'b0;
            m_pre[k] = 0; m_mtip[k] = 1'b0; m_prdata[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        int          nb, dv, a;
        logic [63:0] t, c;
        bit          stop, tick, time_wr;
        nb = nbk(k);
        dv = divk(k);
        stop = dbg_mode && dbg_stop;
        tick = !stop && (m_pre[k] == dv - 1);
        if (psel && !penable) m_prdata[k] = model_read(k, paddr);
        t = m_time[k];
        c = m_cmp[k];
        time_wr = 0;
        if (psel && penable && pwrite && ((int'(paddr) % nb) == 0)) begin
            for (int j = 0; j < nb; j++) begin
                if (pstrb[j]) begin
                    a = int'(paddr) + j;
                    if (a == 0) begin
                        m_msip[k] = pwdata[0];
                    end else if (a >= 'h4000 && a < 'h4008) begin
                        c[(a - 'h4000)*8 +: 8] = pwdata[j*8 +: 8];
                    end else if (a >= 'hBFF8 && a < 'hC000) begin
                        t[(a - 'hBFF8)*8 +: 8] = pwdata[j*8 +: 8];
                        time_wr = 1;
                    end
                end
            end
        end
        if (time_wr) begin
            m_time[k] = t;
            m_pre[k]  = 0;
        end else if (!stop) begin
            if (tick) m_time[k] = m_time[k] + 64'd1;
            m_pre[k] = (m_pre[k] + 1) % dv;
        end
        m_cmp[k]  = c;
        m_mtip[k] = (m_time[k] >= m_cmp[k]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_value("d64_mtime",  d64_mtime,  m_time[0]);
            check_value("d64_mtip",   d64_mtip,   m_mtip[0]);
            check_value("d64_msip",   d64_msip,   m_msip[0]);
            check_value("d64_prdata", d64_prdata, m_prdata[0]);
            check_value("d64_pready", d64_pready, 1);
            check_value("d32_mtime",  d32_mtime,  m_time[1]);
            check_value("d32_mtip",   d32_mtip,   m_mtip[1]);
            check_value("d32_msip",   d32_msip,   m_msip[1]);
            check_value("d32_prdata", d32_prdata, m_prdata[1][31:0]);
            check_value("d32_pready", d32_pready, 1);
        end
    end

    // ---------------- bus tasks
    task automatic apb_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
        @(negedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk); #1;
        penable = 1'b1;
        @(negedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a);
        @(negedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); #1;
        penable = 1'b1;
        @(negedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [63:0] frozen0, frozen1, d;
        logic [15:0] a;
        logic [7:0]  s;
        bit          found;

        rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; dbg_mode = 1'b0; dbg_stop = 1'b0;
        #1 rst_n = 1'b0;
        chk_on = 1;
        #1;
        check_value("rst_mtime",  d64_mtime,  0);
        check_value("rst_prdata", d64_prdata, 0);
        check_value("rst_mtip",   d64_mtip,   0);
        check_value("rst_msip",   d64_msip,   0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Free-running count; the div-4 instance ticks first on the 4th edge.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check_value("cnt_d64", d64_mtime, 64'(i));
            check_value("cnt_d32", d32_mtime, 64'(i / 4));
            check_value("cnt_mtip", d64_mtip, 0);
        end

        apb_read(CLINT_MTIMECMP_OFS);
        check_value("rst_cmp_d64", d64_prdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check_value("rst_cmp_d32", d32_prdata, 32'hFFFF_FFFF);

        // Compare threshold at 0x10
        apb_write(CLINT_MTIME_OFS, 64'h0, 8'hFF);
        apb_write(CLINT_MTIMECMP_OFS, 64'h10, 8'hFF);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (d64_mtime == 64'hF) check_value("mtip_below_cmp", d64_mtip, 0);
            if (d64_mtime == 64'h10) begin
                found = 1;
                check_value("mtip_at_cmp", d64_mtip, 1);
            end
        end
        check_value("mtip_reach_0x10", found, 1);
        apb_write(CLINT_MTIMECMP_OFS, 64'h100, 8'hFF);
        check_value("mtip_clear", d64_mtip, 0);

        // mtime write on a tick cycle: exactly the written value, then one tick before the read samples
        apb_write(CLINT_MTIME_OFS, 64'h5, 8'hFF);
        check_value("mtime_wr", d64_mtime, 64'h5);
        apb_read(CLINT_MTIME_OFS);
        check_value("mtime_rd", d64_prdata, 64'h6);

        // Debug stop-time freeze
        @(negedge clk); #1;
        dbg_mode = 1'b1; dbg_stop = 1'b1;
        frozen0 = m_time[0];
        frozen1 = m_time[1];
        repeat (10) @(negedge clk);
        check_value("freeze_d64", d64_mtime, frozen0);
        check_value("freeze_d32", d32_mtime, frozen1);
        #1 dbg_mode = 1'b0; dbg_stop = 1'b0;
        repeat (9) @(negedge clk);

        // Software interrupt bit
        apb_write(CLINT_MSIP_OFS, 64'h1, 8'hFF);
        check_value("msip_set", d64_msip, 1);
        apb_write(CLINT_MSIP_OFS, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        apb_read(CLINT_MSIP_OFS);
        check_value("msip_rd_d64", d64_prdata, 64'h1);
        check_value("msip_rd_d32", d32_prdata, 32'h1);
        apb_write(CLINT_MSIP_OFS, 64'h0, 8'hFF);
        check_value("msip_clr", d64_msip, 0);
        apb_write(CLINT_MSIP_OFS, 64'h1, 8'hFF);
        apb_read(CLINT_MSIP_OFS);

        // Reset during the access phase of an MSIP write
        @(negedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = CLINT_MSIP_OFS; pwdata = 64'h1; pstrb = 8'hFF;
        @(negedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_msip",   d64_msip,   0);
        check_value("arst_msip32", d32_msip,   0);
        check_value("arst_mtime",  d64_mtime,  0);
        check_value("arst_mtime32", d32_mtime, 0);
        check_value("arst_prdata", d64_prdata, 0);
        check_value("arst_mtip",   d64_mtip,   0);
        @(negedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_value("abort_msip", d64_msip, 0);

        // 64-bit wrap against the reset compare value
        apb_write(CLINT_MTIME_OFS, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        check_value("wrap_fe", d64_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        check_value("wrap_fe_mtip", d64_mtip, 0);
        @(negedge clk);
        check_value("wrap_ff", d64_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        check_value("wrap_ff_mtip", d64_mtip, 1);
        @(negedge clk);
        check_value("wrap_0", d64_mtime, 64'h0);
        check_value("wrap_0_mtip", d64_mtip, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            dbg_mode = ($urandom_range(0, 4) == 0);
            dbg_stop = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 8))
                0: a = 16'h0000;
                1: a = 16'h0004;
                2: a = 16'h4000;
                3: a = 16'h4004;
                4: a = 16'hBFF8;
                5: a = 16'hBFFC;
                6: a = 16'($urandom);
                7: a = 16'h4002;
                default: a = 16'hBFF8;
            endcase
            d = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom};
            s = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 9) < 6) apb_write(a, d, s);
            else apb_read(a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        dbg_mode = 1'b0; dbg_stop = 1'b0;
        repeat (5) @(negedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
